pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, max cycles to wait for imem_ack before fault (range 1..255).
REQ-002 SHALL have parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-003 SHALL have port CLK  input  1  the single clock; all state changes on rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port extendImmediate  input  32  extended immediate from the sign/zero extender, used as branch offset.
REQ-006 SHALL have port PCSrc  input  2  next-PC select: 00 PC+4, 01 branch, 10 jump, 11 hold.
REQ-007 SHALL have port ExecDone  input  1  one-cycle pulse from datapath: current instruction finished.
REQ-008 SHALL have port Halt  input  1  sampled with ExecDone; stop fetching.
REQ-009 SHALL have port imem_req  output  1  instruction memory read request.
REQ-010 SHALL have port imem_addr  output  32  fetch address.
REQ-011 SHALL have port imem_ack  input  1  memory data valid this cycle.
REQ-012 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-013 SHALL have port curPC  output  32  address of instruction in IR.
REQ-014 SHALL have port PC4  output  32  curPC+4, combinational.
REQ-015 SHALL have port instruction  output  32  instruction register contents.
REQ-016 SHALL have port immediate  output  16  instruction[15:0], to the extender.
REQ-017 SHALL have port instValid  output  1  high while IR holds an instruction under execution.
REQ-018 SHALL have ports halted, fault  output  1 each  sticky status flags.

Function
REQ-019 SHALL implement FSM states START, FETCH, EXEC, HALTED, FAULT.
REQ-020 START: one cycle after reset, no request; unconditionally -> FETCH.
REQ-021 FETCH: imem_req=1, imem_addr=curPC, both held stable until ack; on imem_ack IR<=imem_rdata, -> EXEC.
REQ-022 instValid SHALL rise the cycle after the capturing ack and stay high throughout EXEC only.
REQ-023 imem_ack outside FETCH SHALL be ignored (IR unchanged).
REQ-024 FETCH SHALL count wait cycles; ack not seen within TIMEOUT cycles of entry -> FAULT, fault<=1, imem_req<=0; ack on exactly cycle TIMEOUT is accepted.
REQ-025 EXEC: wait for ExecDone; ExecDone in other states ignored.
REQ-026 On ExecDone with Halt=0: PC updated per PCSrc, -> FETCH next cycle.
REQ-027 Next PC: 00 -> PC+4; 01 -> PC+4+(extendImmediate<<2); 10 -> {PC4[31:28], instruction[25:0], 2'b00}; 11 -> curPC (refetch same address).
REQ-028 All PC arithmetic SHALL be 32-bit modulo 2^32 (PC 32'hFFFFFFFC + 4 -> 0; negative offsets wrap).
REQ-029 On ExecDone with Halt=1: PC unchanged, -> HALTED, halted<=1; Halt overrides PCSrc.
REQ-030 HALTED and FAULT SHALL be terminal until Reset; imem_req=0, instValid=0.
REQ-031 immediate SHALL always equal instruction[15:0]; PC4 SHALL always equal curPC+4.

Reset
REQ-032 Reset=1 at a rising edge SHALL set curPC=RESET_PC, instruction=0, imem_req=0, instValid=0, halted=0, fault=0, wait counter=0, state START.
REQ-033 Reset SHALL take priority over all other inputs in any state, including mid-FETCH (request dropped next cycle, pending ack ignored).

Verification
REQ-034 Reset then ack after 2 wait cycles with rdata=32'h2001000A -> imem_addr=0, IR=32'h2001000A, immediate=16'h000A, instValid high.
REQ-035 curPC=32'h00000010, PCSrc=01, extendImmediate=32'hFFFFFFFE, ExecDone -> next imem_addr=32'h0000000C.
REQ-036 curPC=32'h10000004, instruction=32'h08000040, PCSrc=10, ExecDone -> next imem_addr=32'h10000100.
REQ-037 No ack for TIMEOUT+1 cycles in FETCH -> fault=1, imem_req=0; late ack leaves IR unchanged; Reset clears fault.
REQ-038 ExecDone with Halt=1 and PCSrc=01 -> halted=1, curPC unchanged, no further imem_req.
REQ-039 Reset asserted mid-FETCH with simultaneous imem_ack -> IR=0, curPC=RESET_PC, state START.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-fetch sequencer: fetches one word per instruction,
// holds it in the IR while the datapath executes, then steps the PC per PCSrc.
module pc_fetch_unit #(
    parameter int          TIMEOUT  = 15,
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] extendImmediate,
    input  logic [1:0]  PCSrc,
    input  logic        ExecDone,
    input  logic        Halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] curPC,
    output logic [31:0] PC4,
    output logic [31:0] instruction,
    output logic [15:0] immediate,
    output logic        instValid,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [2:0] {START, FETCH, EXEC, HALTED, FAULT} stateT;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    stateT       state;
    logic [7:0]  waitCnt;
    logic [31:0] nextPC;

    assign PC4       = curPC + 32'd4;
    assign immediate = instruction[15:0];
    assign imem_addr = curPC;

    always_comb begin
        nextPC = PC4;
        case (PCSrc)
            2'b01:   nextPC = PC4 + (extendImmediate << 2);
            2'b10:   nextPC = {PC4[31:28], instruction[25:0], 2'b00};
            2'b11:   nextPC = curPC;
            default: nextPC = PC4;
        endcase
    end

    // waitCnt holds the number of ack-less FETCH cycles already seen, so an ack
    // arriving while waitCnt == TIMEOUT is still accepted.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state       <= START;
            curPC       <= RESET_PC;
            instruction <= 32'd0;
            imem_req    <= 1'b0;
            instValid   <= 1'b0;
            halted      <= 1'b0;
            fault       <= 1'b0;
            waitCnt     <= 8'd0;
        end else begin
            case (state)
                START: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                    waitCnt  <= 8'd0;
                end
                FETCH: begin
                    if (imem_ack) begin
                        instruction <= imem_rdata;
                        imem_req    <= 1'b0;
                        instValid   <= 1'b1;
                        state       <= EXEC;
                    end else if (waitCnt == TIMEOUT_CNT) begin
                        imem_req <= 1'b0;
                        fault    <= 1'b1;
                        state    <= FAULT;
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end
                EXEC: begin
                    if (ExecDone) begin
                        instValid <= 1'b0;
                        if (Halt) begin
                            halted <= 1'b1;
                            state  <= HALTED;
                        end else begin
                            curPC    <= nextPC;
                            imem_req <= 1'b1;
                            waitCnt  <= 8'd0;
                            state    <= FETCH;
                        end
                    end
                end
                HALTED, FAULT: begin
                    imem_req  <= 1'b0;
                    instValid <= 1'b0;
                end
                default: state <= START;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized scoreboard bench for pc_fetch_unit: the driver predicts every fetch
// (address and word) into a queue, and a monitor checks each memory handshake.
module tb_pc_fetch_unit;

    localparam int          TIMEOUT  = 5;
    localparam logic [31:0] RESET_PC = 32'h00000000;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] extendImmediate = 32'd0;
    logic [1:0]  PCSrc = 2'b00;
    logic        ExecDone = 1'b0;
    logic        Halt = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] curPC;
    logic [31:0] PC4;
    logic [31:0] instruction;
    logic [15:0] immediate;
    logic        instValid;
    logic        halted;
    logic        fault;

    pc_fetch_unit #(.TIMEOUT(TIMEOUT), .RESET_PC(RESET_PC)) dut (
        .CLK(CLK), .Reset(Reset), .extendImmediate(extendImmediate), .PCSrc(PCSrc),
        .ExecDone(ExecDone), .Halt(Halt), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .curPC(curPC), .PC4(PC4),
        .instruction(instruction), .immediate(immediate), .instValid(instValid),
        .halted(halted), .fault(fault)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] word;
    } fetchT;

    fetchT       expQ[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] mPC;
    logic [31:0] mWord;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Monitor: every accepted handshake must match the next predicted fetch, and
    // the following cycle must show that word in the IR with the PC outputs.
    initial begin
        fetchT cur;
        logic  pending;
        pending = 1'b0;
        cur = '0;
        forever begin
            @(negedge CLK);
            if (pending) begin
                checkOutput("irAfterAck", instruction, cur.word);
                checkOutput("immAfterAck", {16'd0, immediate}, {16'd0, cur.word[15:0]});
                checkOutput("validAfterAck", {31'd0, instValid}, 32'd1);
                checkOutput("curPCAfterAck", curPC, cur.addr);
                checkOutput("pc4AfterAck", PC4, cur.addr + 32'd4);
                pending = 1'b0;
            end
            if (imem_req && imem_ack && !Reset) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedFetch", imem_addr, 32'hxxxxxxxx);
                end else begin
                    cur = expQ.pop_front();
                    checkOutput("fetchAddr", imem_addr, cur.addr);
                    pending = 1'b1;
                end
            end
        end
    end

    task automatic doReset();
        Reset = 1'b1;
        imem_ack = 1'b0;
        ExecDone = 1'b0;
        Halt = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        Reset = 1'b0;
        mPC = RESET_PC;
        mWord = 32'd0;
    endtask

    task automatic waitReq(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin
                ok = 1'b1;
                break;
            end
            @(posedge CLK);
            #1;
        end
        if (!ok) checkOutput("reqTimeout", {31'd0, imem_req}, 32'd1);
    endtask

    // Serve one fetch after `delay` ack-less cycles, with junk ExecDone traffic.
    task automatic applyStimulus(input int delay, input logic [31:0] word);
        logic ok;
        waitReq(ok);
        if (ok) begin
            expQ.push_back({mPC, word});
            mWord = word;
            for (int i = 0; i < delay; i++) begin
                imem_ack = 1'b0;
                ExecDone = 1'($urandom);
                Halt = 1'($urandom);
                PCSrc = 2'($urandom);
                @(posedge CLK);
                #1;
            end
            ExecDone = 1'b0;
            Halt = 1'b0;
            imem_ack = 1'b1;
            imem_rdata = word;
            @(posedge CLK);
            #1;
            imem_ack = 1'b0;
            imem_rdata = $urandom;
        end
    endtask

    task automatic doExec(input int waitCycles, input logic [1:0] src, input logic [31:0] imm, input logic halt);
        logic [31:0] p4;
        for (int i = 0; i < waitCycles; i++) begin
            imem_ack = 1'($urandom);
            imem_rdata = $urandom;
            @(posedge CLK);
            #1;
        end
        imem_ack = 1'b0;
        checkOutput("irHeldInExec", instruction, mWord);
        checkOutput("validInExec", {31'd0, instValid}, 32'd1);
        ExecDone = 1'b1;
        Halt = halt;
        PCSrc = src;
        extendImmediate = imm;
        p4 = mPC + 32'd4;
        if (!halt) begin
            case (src)
                2'b00: mPC = p4;
                2'b01: mPC = p4 + imm * 32'd4;
                2'b10: mPC = (p4 & 32'hF0000000) | ((mWord & 32'h03FFFFFF) * 32'd4);
                default: mPC = mPC;
            endcase
        end
        @(posedge CLK);
        #1;
        ExecDone = 1'b0;
        Halt = 1'b0;
    endtask

    initial begin
        logic        ok;
        logic [31:0] imm;
        mPC = RESET_PC;
        mWord = 32'd0;

        doReset();
        checkOutput("rstCurPC", curPC, RESET_PC);
        checkOutput("rstIR", instruction, 32'd0);
        checkOutput("rstReq", {31'd0, imem_req}, 32'd0);
        checkOutput("rstValid", {31'd0, instValid}, 32'd0);
        checkOutput("rstFlags", {30'd0, halted, fault}, 32'd0);

        applyStimulus(2, 32'h2001000A);
        checkOutput("firstImmediate", {16'd0, immediate}, 32'h0000000A);
        for (int i = 0; i < 4; i++) begin
            doExec(1, 2'b00, 32'd0, 1'b0);
            applyStimulus((i == 0) ? TIMEOUT : i, $urandom);
        end
        checkOutput("pcAt10", curPC, 32'h00000010);
        doExec(0, 2'b01, 32'hFFFFFFFE, 1'b0);
        applyStimulus(0, $urandom);
        doExec(2, 2'b01, 32'h03FFFFFD, 1'b0);
        applyStimulus(1, 32'h08000040);
        doExec(0, 2'b10, 32'd0, 1'b0);
        applyStimulus(0, $urandom);
        checkOutput("jumpTarget", curPC, 32'h10000100);

        for (int i = 0; i < 30; i++) begin
            doExec($urandom_range(0, 3), 2'($urandom), $urandom, 1'b0);
            applyStimulus($urandom_range(0, TIMEOUT), $urandom);
        end

        imm = (32'hFFFFFFFC - (mPC + 32'd4)) >> 2;
        doExec(0, 2'b01, imm, 1'b0);
        applyStimulus(0, $urandom);
        checkOutput("pcTop", curPC, 32'hFFFFFFFC);
        doExec(0, 2'b00, 32'd0, 1'b0);
        applyStimulus(0, $urandom);
        checkOutput("pcWrap", curPC, 32'h00000000);

        doExec(1, 2'b01, 32'h00000010, 1'b1);
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            imem_ack = 1'b1;
            if (imem_req || instValid) ok = 1'b0;
            @(posedge CLK);
            #1;
        end
        imem_ack = 1'b0;
        checkOutput("haltedFlag", {31'd0, halted}, 32'd1);
        checkOutput("haltedPC", curPC, mPC);
        checkOutput("haltedQuiet", {31'd0, ok}, 32'd1);

        doReset();
        waitReq(ok);
        repeat (TIMEOUT) @(posedge CLK);
        #1;
        checkOutput("noFaultAtLimit", {31'd0, fault}, 32'd0);
        @(posedge CLK);
        #1;
        checkOutput("faultFlag", {31'd0, fault}, 32'd1);
        checkOutput("faultReq", {31'd0, imem_req}, 32'd0);
        imem_ack = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        repeat (2) @(posedge CLK);
        #1;
        imem_ack = 1'b0;
        checkOutput("lateAckIR", instruction, 32'd0);
        checkOutput("faultValid", {31'd0, instValid}, 32'd0);
        doReset();
        checkOutput("faultCleared", {31'd0, fault}, 32'd0);

        applyStimulus(0, 32'h12345678);
        doExec(0, 2'b00, 32'd0, 1'b0);
        waitReq(ok);
        Reset = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'hCAFEF00D;
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        imem_ack = 1'b0;
        mPC = RESET_PC;
        checkOutput("midResetIR", instruction, 32'd0);
        checkOutput("midResetPC", curPC, RESET_PC);
        checkOutput("midResetReq", {31'd0, imem_req}, 32'd0);
        applyStimulus(1, 32'h0BADF00D);
        doExec(0, 2'b00, 32'd0, 1'b0);

        repeat (2) @(posedge CLK);
        checkOutput("pendingFetches", expQ.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
